// File: rtl/seq_media.sv
// rtl/seq_media.sv - sequencer issuing the clrld/addld/add/div2/disp stream that averages 2^K operands
module seq_media #(
  parameter int WIDTH = 8,
  parameter int K     = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Iniciar,
  input  logic             Cancelar,
  input  logic [WIDTH-1:0] Entrada,
  input  logic             Entrada_valid,
  output logic             Entrada_ready,
  output logic [2:0]       Instrucao,
  output logic             Inst_valida,
  output logic [WIDTH-1:0] Operando,
  output logic             Ocupado,
  output logic             Pronto
);

  localparam logic [2:0] I_CLRLD = 3'b000;
  localparam logic [2:0] I_ADDLD = 3'b001;
  localparam logic [2:0] I_ADD   = 3'b010;
  localparam logic [2:0] I_DIV2  = 3'b011;
  localparam logic [2:0] I_DISP  = 3'b100;
  localparam logic [2:0] I_NOP   = 3'b111;
  localparam int OP_COUNT = 1 << K;

  typedef enum logic [2:0] {
    IDLE, CARREGA, SOMA_LD, SOMA, DIVIDE, MOSTRA
  } state_t;

  state_t     state;
  logic [K:0] op_cnt;
  logic [2:0] div_cnt;
  logic       accept;

  assign Entrada_ready = ((state == CARREGA) || (state == SOMA_LD)) && !Cancelar;
  assign Ocupado       = (state != IDLE);
  assign accept        = Entrada_valid && Entrada_ready;

  // Issue outputs default to NOP every edge; only the acting state overrides them for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      Instrucao   <= I_NOP;
      Inst_valida <= 1'b0;
      Operando    <= '0;
      Pronto      <= 1'b0;
      op_cnt      <= '0;
      div_cnt     <= '0;
    end else begin
      Instrucao   <= I_NOP;
      Inst_valida <= 1'b0;
      Pronto      <= 1'b0;
      if (state != IDLE && Cancelar) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            op_cnt  <= '0;
            div_cnt <= '0;
            if (Iniciar && !Cancelar) state <= CARREGA;
          end
          CARREGA: begin
            if (accept) begin
              Instrucao   <= I_CLRLD;
              Inst_valida <= 1'b1;
              Operando    <= Entrada;
              op_cnt      <= (K+1)'(1);
              state       <= (K == 0) ? MOSTRA : SOMA_LD;
            end
          end
          SOMA_LD: begin
            if (accept) begin
              Instrucao   <= I_ADDLD;
              Inst_valida <= 1'b1;
              Operando    <= Entrada;
              op_cnt      <= op_cnt + 1'b1;
              state       <= SOMA;
            end
          end
          SOMA: begin
            Instrucao   <= I_ADD;
            Inst_valida <= 1'b1;
            state       <= (int'(op_cnt) == OP_COUNT) ? DIVIDE : SOMA_LD;
          end
          DIVIDE: begin
            Instrucao   <= I_DIV2;
            Inst_valida <= 1'b1;
            div_cnt     <= div_cnt + 1'b1;
            if (int'(div_cnt) == K - 1) state <= MOSTRA;
          end
          MOSTRA: begin
            Instrucao   <= I_DISP;
            Inst_valida <= 1'b1;
            Pronto      <= 1'b1;
            state       <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seq_media.sv
// tb/tb_seq_media.sv - randomized bench for seq_media with K=0,1,2 instances against an issue-stream model
module tb_seq_media;

  localparam logic [2:0] CLRLD = 3'b000;
  localparam logic [2:0] ADDLD = 3'b001;
  localparam logic [2:0] ADD   = 3'b010;
  localparam logic [2:0] DIV2  = 3'b011;
  localparam logic [2:0] DISP  = 3'b100;
  localparam logic [2:0] NOP   = 3'b111;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       iniciar[3], cancelar[3], entrada_valid[3], entrada_ready[3];
  logic       inst_valida[3], ocupado[3], pronto[3];
  logic [7:0] entrada[3], operando[3];
  logic [2:0] instrucao[3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    seq_media #(.WIDTH(8), .K(g)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .Iniciar      (iniciar[g]),
      .Cancelar     (cancelar[g]),
      .Entrada      (entrada[g]),
      .Entrada_valid(entrada_valid[g]),
      .Entrada_ready(entrada_ready[g]),
      .Instrucao    (instrucao[g]),
      .Inst_valida  (inst_valida[g]),
      .Operando     (operando[g]),
      .Ocupado      (ocupado[g]),
      .Pronto       (pronto[g])
    );
  end

  always #5 clk = ~clk;

  // One entry per clock edge of a run: what that edge issues and whether the source is offered ready before it.
  typedef struct {
    logic [2:0] ins;
    bit         rdy;
    logic [7:0] op;
  } ev_t;

  ev_t        ev[$];
  logic [7:0] ops[16];
  int         stl[16];
  int         cur_k;
  int         n_chk = 0;
  int         n_bad = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s (K=%0d): got %0h expected %0h at %0t", tag, cur_k, got, exp, $time);
    end
  endtask

  function automatic void build(int k);
    ev.delete();
    for (int i = 0; i < (1 << k); i++) begin
      for (int s = 0; s < stl[i]; s++) ev.push_back('{NOP, 1'b1, 8'h00});
      ev.push_back('{(i == 0) ? CLRLD : ADDLD, 1'b1, ops[i]});
      if (i > 0) ev.push_back('{ADD, 1'b0, 8'h00});
    end
    for (int d = 0; d < k; d++) ev.push_back('{DIV2, 1'b0, 8'h00});
    ev.push_back('{DISP, 1'b0, 8'h00});
  endfunction

  function automatic int div_start(int k);
    int idx = 0;
    for (int i = 0; i < (1 << k); i++) idx += stl[i] + ((i == 0) ? 1 : 2);
    return idx;
  endfunction

  task automatic rand_ops();
    for (int i = 0; i < 16; i++) begin
      ops[i] = 8'($urandom);
      stl[i] = $urandom_range(0, 3);
    end
  endtask

  task automatic sample(logic [2:0] ins, bit pr, bit busy, bit rdy);
    check("instrucao", instrucao[cur_k], ins);
    check("inst_valida", inst_valida[cur_k], ins != NOP);
    check("pronto", pronto[cur_k], pr);
    check("ocupado", ocupado[cur_k], busy);
    check("entrada_ready", entrada_ready[cur_k], rdy);
  endtask

  task automatic idle_inputs(int k);
    iniciar[k]       = 1'b0;
    cancelar[k]      = 1'b0;
    entrada_valid[k] = 1'b0;
    entrada[k]       = 8'($urandom);
  endtask

  task automatic idle(int k, int n);
    cur_k = k;
    repeat (n) begin
      @(negedge clk);
      #1;
      sample(NOP, 1'b0, 1'b0, 1'b0);
    end
  endtask

  // Entered at a negedge with instance k in IDLE; leaves it in IDLE with inputs quiet.
  task automatic run(int k, int cancel_at, int reset_at);
    logic [2:0] prev;
    cur_k = k;
    build(k);
    if (cancel_at == -2) cancel_at = $urandom_range(0, ev.size() - 1);
    iniciar[k]       = 1'b1;
    cancelar[k]      = 1'b0;
    entrada_valid[k] = 1'($urandom);
    entrada[k]       = 8'($urandom);
    #1;
    check("start_ocupado", ocupado[k], 1'b0);
    @(negedge clk);
    for (int t = 0; t < ev.size(); t++) begin
      iniciar[k]  = 1'($urandom);
      cancelar[k] = (t == cancel_at);
      if (ev[t].rdy && ev[t].ins == NOP) begin
        entrada_valid[k] = 1'b0;
        entrada[k]       = 8'($urandom);
      end else if (ev[t].rdy) begin
        entrada_valid[k] = 1'b1;
        entrada[k]       = ev[t].op;
      end else begin
        entrada_valid[k] = 1'($urandom);
        entrada[k]       = 8'($urandom);
      end
      #1;
      prev = (t == 0) ? NOP : ev[t-1].ins;
      sample(prev, 1'b0, 1'b1, ev[t].rdy && (t != cancel_at));
      if (prev == CLRLD || prev == ADDLD) check("operando", operando[k], ev[t-1].op);
      if (t == reset_at) begin
        rst_n = 1'b0;
        #1;
        sample(NOP, 1'b0, 1'b0, 1'b0);
        check("operando_rst", operando[k], 8'h00);
        @(negedge clk);
        idle_inputs(k);
        rst_n = 1'b1;
        return;
      end
      if (t == cancel_at) begin
        @(negedge clk);
        idle_inputs(k);
        #1;
        sample(NOP, 1'b0, 1'b0, 1'b0);
        return;
      end
      @(negedge clk);
    end
    idle_inputs(k);
    #1;
    sample(DISP, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) idle_inputs(k);
    repeat (2) @(negedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      cur_k = k;
      sample(NOP, 1'b0, 1'b0, 1'b0);
      check("operando_reset", operando[k], 8'h00);
    end
    rst_n = 1'b1;
    @(negedge clk);

    ops[0] = 8'd10; ops[1] = 8'd20; stl[0] = 0; stl[1] = 0;
    run(1, -1, -1);
    idle(1, 2);

    for (int i = 0; i < 4; i++) begin
      ops[i] = 8'(4 * (i + 1));
      stl[i] = 3;
    end
    run(2, -1, -1);
    idle(2, 1);

    ops[0] = 8'd7; stl[0] = 0;
    run(0, -1, -1);
    idle(0, 1);

    rand_ops();
    run(1, -1, stl[0] + 1);
    rand_ops();
    run(1, -1, -1);
    idle(1, 1);

    rand_ops();
    run(2, div_start(2) + 1, -1);
    idle(2, 1);

    cur_k = 2;
    iniciar[2]  = 1'b1;
    cancelar[2] = 1'b1;
    @(negedge clk);
    idle_inputs(2);
    #1;
    sample(NOP, 1'b0, 1'b0, 1'b0);
    idle(2, 1);

    for (int r = 0; r < 40; r++) begin
      int k;
      k = $urandom_range(0, 2);
      rand_ops();
      run(k, ($urandom_range(0, 4) == 0) ? -2 : -1, -1);
      if ($urandom_range(0, 1) == 1) idle(k, $urandom_range(1, 3));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
